shift_ctrl: RTL and testbench
=============================

SHIFT_CTRL -- requirements
Module: shift_ctrl

Interface
REQ-001 Parameter DEPTH, default 32, number of 8-bit stages in the controlled shift chain; legal range 2..64.
REQ-002 Parameter GAP, default 0, idle cycles inserted after each chain shift before the next byte is presented; legal range 0..255.
REQ-003 clk  input  1  single clock; all state SHALL change on the rising edge only.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 start  input  1  request to load the chain and stream it out; sampled only in IDLE.
REQ-006 abort  input  1  cancel any operation in progress; sampled in every state.
REQ-007 chain_out  input  8  tail byte of the shift chain.
REQ-008 chain_load  output  1  one-cycle pulse; loads all parallel chain inputs.
REQ-009 chain_shift  output  1  one-cycle pulse; advances the chain one stage toward the tail.
REQ-010 out_data  output  8  byte presented to the consumer.
REQ-011 out_valid  output  1  out_data is valid.
REQ-012 out_ready  input  1  consumer accepts out_data when out_valid is also 1.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 done  output  1  one-cycle pulse when DEPTH bytes have been transferred.
REQ-015 byte_cnt  output  7  number of bytes accepted in the current pass.

Function
REQ-016 All outputs SHALL be registered; the FSM SHALL have the states IDLE, LOAD, PRESENT, SHIFT, GAP_WAIT and DONE.
REQ-017 In IDLE with start=1, the next state SHALL be LOAD; chain_load SHALL be 1 for exactly the LOAD cycle, and byte_cnt SHALL be cleared to 0 on entry to LOAD.
REQ-018 LOAD SHALL go to PRESENT; on entry to PRESENT, out_data SHALL capture chain_out and out_valid SHALL be driven to 1.
REQ-019 In PRESENT, out_data and out_valid SHALL hold stable until out_valid&&out_ready is sampled, however long out_ready stays low.
REQ-020 On a handshake in PRESENT:
- byte_cnt SHALL increment and out_valid SHALL drop on the next cycle.
- If the incremented count equals DEPTH, the next state SHALL be DONE.
- Otherwise, the next state SHALL be SHIFT.
REQ-021 SHIFT SHALL last one cycle with chain_shift=1; the next state SHALL be GAP_WAIT if GAP>0, else PRESENT.
REQ-022 GAP_WAIT SHALL last exactly GAP cycles, counted by an 8-bit down-counter, then go to PRESENT.
REQ-023 DONE SHALL last one cycle with done=1, then go to IDLE (or LOAD per REQ-032); byte_cnt SHALL hold DEPTH until the next LOAD.
REQ-024 Minimum cycles per byte with out_ready held at 1 SHALL be 2+GAP (PRESENT, SHIFT, GAP_WAIT).
REQ-025 start SHALL be ignored outside IDLE.
REQ-026 abort=1 in any non-IDLE state SHALL force IDLE on the next edge:
- out_valid, chain_shift, chain_load and done SHALL be 0.
- byte_cnt SHALL hold its value.
REQ-027 If abort and a handshake occur in the same cycle, abort SHALL win: byte_cnt SHALL NOT increment and done SHALL NOT pulse.
REQ-028 If abort and start are both 1 in IDLE, the block SHALL stay in IDLE.
REQ-029 chain_load and chain_shift SHALL never be 1 in the same cycle.

Reset
REQ-030 rst=1 at a clock edge SHALL force, on that edge and regardless of any other input:
- state = IDLE; byte_cnt, GAP counter and out_data = 0.
- chain_load, chain_shift, out_valid, busy and done = 0.
REQ-031 rst asserted mid-transfer SHALL discard the pass; the chain contents are not touched by this block.

Configuration
REQ-032 Macro SHIFT_CTRL_LOOP_EN: when defined, DONE SHALL go directly to LOAD (continuous reload and stream) until abort; done SHALL still pulse once per pass. When not defined, DONE SHALL go to IDLE.

Verification
REQ-033 DEPTH=32, GAP=0, chain loaded with 0x00..0x1F, out_ready=1, start pulse -> 32 bytes 0x1F,0x1E,... in tail order, one every 2 cycles, done at byte 32, byte_cnt=32, busy low after DONE.
REQ-034 GAP=3, out_ready=1 -> exactly 5 cycles between successive out_valid rising edges; chain_shift pulses 31 times in total.
REQ-035 out_ready held 0 for 10 cycles at byte 5 -> out_data and out_valid stable for all 10 cycles, no chain_shift, byte_cnt stays 4.
REQ-036 abort in the same cycle as the handshake of byte 7 -> IDLE next cycle, byte_cnt=6, no done; start while busy is ignored; abort+start in IDLE -> stays IDLE.
REQ-037 rst pulsed during GAP_WAIT -> all outputs 0 on the next cycle; a new start then performs a full 32-byte pass.
REQ-038 SHIFT_CTRL_LOOP_EN defined -> done pulses every 32 bytes, chain_load recurs the cycle after done, and abort stops the stream.

Source files
------------

// File: rtl/shift_ctrl_if.sv
// Bundle of the shift_ctrl control, chain and consumer signals.
// master = shift_ctrl itself, slave = the chain plus consumer environment.
interface shift_ctrl_if;
  logic       start;
  logic       abort;
  logic [7:0] chain_out;
  logic       chain_load;
  logic       chain_shift;
  // Consumer handshake: a byte moves when out_valid && out_ready are both 1
  // at a rising edge; out_data/out_valid hold while out_valid && !out_ready.
  logic [7:0] out_data;
  logic       out_valid;
  logic       out_ready;
  logic       busy;
  logic       done;
  logic [6:0] byte_cnt;
  logic [2:0] state_dbg;

  modport master (
    input  start, abort, chain_out, out_ready,
    output chain_load, chain_shift, out_data, out_valid, busy, done, byte_cnt, state_dbg
  );

  modport slave (
    output start, abort, chain_out, out_ready,
    input  chain_load, chain_shift, out_data, out_valid, busy, done, byte_cnt, state_dbg
  );
endinterface

// File: rtl/shift_ctrl.sv
// Loads an external DEPTH-stage byte chain and streams its tail out over a valid/ready port.
// Define SHIFT_CTRL_LOOP_EN to reload and restream continuously until abort.
module shift_ctrl #(
  parameter int DEPTH = 32,
  parameter int GAP   = 0
) (
  input  logic         clk,
  input  logic         rst,
  shift_ctrl_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_PRESENT  = 3'd2,
    S_SHIFT    = 3'd3,
    S_GAP_WAIT = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  localparam logic [6:0] DEPTH_LAST = 7'(DEPTH - 1);
  localparam logic [7:0] GAP_LOAD   = (GAP > 0) ? 8'(GAP - 1) : 8'd0;

  state_t     state;
  state_t     state_nx;
  logic [7:0] gap_cnt;
  logic       hs;

  assign hs            = (state == S_PRESENT) && bus.out_valid && bus.out_ready;
  assign bus.state_dbg = state;

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:     if (bus.start) state_nx = S_LOAD;
      S_LOAD:     state_nx = S_PRESENT;
      S_PRESENT:  if (hs) state_nx = (bus.byte_cnt == DEPTH_LAST) ? S_DONE : S_SHIFT;
      S_SHIFT:    state_nx = (GAP > 0) ? S_GAP_WAIT : S_PRESENT;
      S_GAP_WAIT: if (gap_cnt == 8'd0) state_nx = S_PRESENT;
      S_DONE: begin
`ifdef SHIFT_CTRL_LOOP_EN
        state_nx = S_LOAD;
`else
        state_nx = S_IDLE;
`endif
      end
      default:    state_nx = S_IDLE;
    endcase
    // abort overrides everything, including a start seen in IDLE
    if (bus.abort) state_nx = S_IDLE;
  end

  // Outputs are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      gap_cnt         <= 8'd0;
      bus.byte_cnt    <= 7'd0;
      bus.out_data    <= 8'd0;
      bus.out_valid   <= 1'b0;
      bus.chain_load  <= 1'b0;
      bus.chain_shift <= 1'b0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
    end else begin
      state           <= state_nx;
      bus.out_valid   <= (state_nx == S_PRESENT);
      bus.chain_load  <= (state_nx == S_LOAD);
      bus.chain_shift <= (state_nx == S_SHIFT);
      bus.busy        <= (state_nx != S_IDLE);
      bus.done        <= (state_nx == S_DONE);

      if (state_nx == S_LOAD) begin
        bus.byte_cnt <= 7'd0;
      end else if (hs && !bus.abort) begin
        bus.byte_cnt <= bus.byte_cnt + 7'd1;
      end

      if ((state_nx == S_PRESENT) && (state != S_PRESENT)) begin
        bus.out_data <= bus.chain_out;
      end

      if (state == S_SHIFT) begin
        gap_cnt <= GAP_LOAD;
      end else if ((state == S_GAP_WAIT) && (gap_cnt != 8'd0)) begin
        gap_cnt <= gap_cnt - 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_shift_ctrl.sv
// Bench for shift_ctrl: two instances (GAP=0 and GAP=3, DEPTH=32), each with a behavioural chain.
module tb_shift_ctrl;

  localparam int DEPTH = 32;
  localparam int GAP_A = 0;
  localparam int GAP_B = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  shift_ctrl_if ifa();
  shift_ctrl_if ifb();

  shift_ctrl #(.DEPTH(DEPTH), .GAP(GAP_A)) dut_a (.clk(clk), .rst(rst), .bus(ifa.master));
  shift_ctrl #(.DEPTH(DEPTH), .GAP(GAP_B)) dut_b (.clk(clk), .rst(rst), .bus(ifb.master));

  logic [1:0] start_v, abort_v, ready_v;
  logic [1:0] o_busy, o_load, o_shift, o_valid, o_done;
  logic [7:0] o_data [2];
  logic [6:0] o_cnt  [2];
  logic [7:0] chain  [2][DEPTH];
  logic [7:0] pat    [2][DEPTH];

  assign ifa.start = start_v[0];  assign ifb.start = start_v[1];
  assign ifa.abort = abort_v[0];  assign ifb.abort = abort_v[1];
  assign ifa.out_ready = ready_v[0];  assign ifb.out_ready = ready_v[1];
  assign ifa.chain_out = chain[0][DEPTH-1];  assign ifb.chain_out = chain[1][DEPTH-1];
  assign o_busy  = {ifb.busy, ifa.busy};
  assign o_load  = {ifb.chain_load, ifa.chain_load};
  assign o_shift = {ifb.chain_shift, ifa.chain_shift};
  assign o_valid = {ifb.out_valid, ifa.out_valid};
  assign o_done  = {ifb.done, ifa.done};
  assign o_data[0] = ifa.out_data;  assign o_data[1] = ifb.out_data;
  assign o_cnt[0]  = ifa.byte_cnt;  assign o_cnt[1]  = ifb.byte_cnt;

  // Behavioural chain: reacts mid-cycle to a pulse so its tail is settled by the next edge.
  // Stage i moves to i+1; the tail is stage DEPTH-1.
  always @(negedge clk) begin
    for (int s = 0; s < 2; s++) begin
      if (o_load[s]) begin
        for (int i = 0; i < DEPTH; i++) chain[s][i] <= pat[s][i];
      end else if (o_shift[s]) begin
        for (int i = DEPTH - 1; i > 0; i--) chain[s][i] <= chain[s][i-1];
        chain[s][0] <= 8'h00;
      end
    end
  end

  typedef struct {
    logic [3:0] in;    // {rst, start, abort, ready}
    logic [4:0] outs;  // {busy, load, shift, valid, done}
    logic [6:0] cnt;
    logic       chk_data;
    logic [7:0] data;
  } vec_t;

  function automatic vec_t mkv(input logic [3:0] in, input logic [4:0] outs,
                               input logic [6:0] cnt, input logic chk, input logic [7:0] data);
    vec_t v;
    v.in = in; v.outs = outs; v.cnt = cnt; v.chk_data = chk; v.data = data;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int s, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s dut%0d: got %0h want %0h", name, s, act, exp);
    end
  endtask

  function automatic int gap_of(input int s);
    return (s == 0) ? GAP_A : GAP_B;
  endfunction

  task automatic fill_random(input int s);
    for (int i = 0; i < DEPTH; i++) pat[s][i] = 8'($urandom_range(0, 255));
  endtask

  // One pass on DUT s. Reference: bytes leave in tail order pat[DEPTH-1] downto pat[0];
  // abort_at = k aborts during the handshake of byte k (0 = no abort).
  task automatic run_pass(input int s, input int ready_pct, input int stall_at, input int abort_at);
    logic [7:0] exp_q [$];
    logic [7:0] held = 8'h00;
    logic [7:0] exp_b;
    logic       rdy;
    logic       prev_wait = 1'b0;
    int acc = 0, stall = 0, done_n = 0, shift_n = 0, last_acc = 0, cyc = 0;
    for (int i = DEPTH - 1; i >= 0; i--) exp_q.push_back(pat[s][i]);
    start_v[s] = 1'b1;
    tick();
    start_v[s] = 1'b0;
    check("load_entry", s, {o_busy[s], o_load[s], o_cnt[s]}, {1'b1, 1'b1, 7'd0});
    while (o_busy[s] && cyc < 4000) begin
      cyc++;
      if (prev_wait) begin
        check("stall_hold", s, {o_valid[s], o_data[s], o_shift[s]}, {1'b1, held, 1'b0});
        check("stall_cnt", s, o_cnt[s], acc);
      end
      if (o_load[s] && o_shift[s]) check("load_shift_excl", s, 1, 0);
      if (o_shift[s]) shift_n++;
      if (o_done[s]) begin
        done_n++;
        check("done_bytes", s, acc, DEPTH);
        check("done_cnt", s, o_cnt[s], DEPTH);
`ifdef SHIFT_CTRL_LOOP_EN
        abort_v[s] = 1'b1;
`endif
      end
      rdy = 1'b0;
      if (o_valid[s]) begin
        rdy = ($urandom_range(0, 99) < ready_pct);
        if (stall_at == acc + 1 && stall < 10) begin
          rdy = 1'b0;
          stall++;
        end
        if (rdy) begin
          if (exp_q.size() > 0) begin
            exp_b = exp_q.pop_front();
            check("byte", s, o_data[s], exp_b);
          end else begin
            check("extra_byte", s, acc, DEPTH - 1);
          end
          check("cnt_at_accept", s, o_cnt[s], acc);
          if (ready_pct == 100 && !prev_wait && acc > 0)
            check("byte_spacing", s, cyc - last_acc, 2 + gap_of(s));
          last_acc = cyc;
          acc++;
          if (acc == abort_at) abort_v[s] = 1'b1;
        end
      end
      prev_wait = o_valid[s] && !rdy;
      held      = o_data[s];
      ready_v[s] = rdy;
      start_v[s] = 1'($urandom_range(0, 1));
      tick();
      abort_v[s] = 1'b0;
    end
    start_v[s] = 1'b0;
    ready_v[s] = 1'b0;
    check("pass_ended", s, cyc < 4000, 1);
    check("bytes_taken", s, acc, (abort_at != 0) ? abort_at : DEPTH);
    check("final_cnt", s, o_cnt[s], (abort_at != 0) ? abort_at - 1 : DEPTH);
    check("done_pulses", s, done_n, (abort_at != 0) ? 0 : 1);
    check("shift_pulses", s, shift_n, (abort_at != 0) ? abort_at - 1 : DEPTH - 1);
    check("idle_outs", s, {o_valid[s], o_load[s], o_shift[s], o_done[s]}, 4'b0000);
  endtask

`ifdef SHIFT_CTRL_LOOP_EN
  task automatic loop_test();
    int dn = 0, acc = 0;
    logic prev_done = 1'b0;
    ready_v[0] = 1'b1;
    start_v[0] = 1'b1;
    tick();
    start_v[0] = 1'b0;
    for (int cyc = 0; cyc < 400 && dn < 2; cyc++) begin
      if (prev_done) check("reload_after_done", 0, o_load[0], 1);
      prev_done = o_done[0];
      if (o_done[0]) begin
        dn++;
        check("loop_bytes", 0, acc, DEPTH * dn);
      end
      if (o_valid[0]) acc++;
      tick();
    end
    check("loop_passes", 0, dn, 2);
    check("reload_after_done", 0, o_load[0], 1);
    abort_v[0] = 1'b1;
    tick();
    abort_v[0] = 1'b0;
    ready_v[0] = 1'b0;
    check("loop_abort", 0, {o_busy[0], o_valid[0], o_load[0]}, 3'b000);
    tick();
    tick();
    check("loop_stays_idle", 0, o_busy[0], 0);
  endtask
`endif

  vec_t vecs [12];

  initial begin
    start_v = 2'b00; abort_v = 2'b00; ready_v = 2'b00;
    for (int i = 0; i < DEPTH; i++) begin
      pat[0][i] = 8'(i);
      pat[1][i] = 8'(i);
    end

    // Cycle table on DUT A (GAP=0), chain loaded with 0x00..0x1F.
    vecs[0]  = mkv(4'b1000, 5'b00000, 7'd0, 1'b1, 8'h00);
    vecs[1]  = mkv(4'b0110, 5'b00000, 7'd0, 1'b0, 8'h00);
    vecs[2]  = mkv(4'b0101, 5'b11000, 7'd0, 1'b0, 8'h00);
    vecs[3]  = mkv(4'b0001, 5'b10010, 7'd0, 1'b1, 8'h1F);
    vecs[4]  = mkv(4'b0001, 5'b10100, 7'd1, 1'b0, 8'h00);
    vecs[5]  = mkv(4'b0000, 5'b10010, 7'd1, 1'b1, 8'h1E);
    vecs[6]  = mkv(4'b0000, 5'b10010, 7'd1, 1'b1, 8'h1E);
    vecs[7]  = mkv(4'b0100, 5'b10010, 7'd1, 1'b1, 8'h1E);
    vecs[8]  = mkv(4'b0001, 5'b10100, 7'd2, 1'b0, 8'h00);
    vecs[9]  = mkv(4'b0010, 5'b00000, 7'd2, 1'b0, 8'h00);
    vecs[10] = mkv(4'b0100, 5'b11000, 7'd0, 1'b0, 8'h00);
    vecs[11] = mkv(4'b0010, 5'b00000, 7'd0, 1'b0, 8'h00);

    for (int k = 0; k < 12; k++) begin
      {rst, start_v[0], abort_v[0], ready_v[0]} = vecs[k].in;
      tick();
      check($sformatf("vec%0d_ctl", k), 0,
            {o_busy[0], o_load[0], o_shift[0], o_valid[0], o_done[0]}, vecs[k].outs);
      check($sformatf("vec%0d_cnt", k), 0, o_cnt[0], vecs[k].cnt);
      if (vecs[k].chk_data) check($sformatf("vec%0d_data", k), 0, o_data[0], vecs[k].data);
    end
    {rst, start_v[0], abort_v[0], ready_v[0]} = 4'b0000;
    tick();

    run_pass(0, 100, 0, 0);     // full pass, 0x1F downward, one byte per 2 cycles
    fill_random(1);
    run_pass(1, 100, 0, 0);     // GAP=3: 5 cycles per byte, 31 shifts
    fill_random(0);
    run_pass(0, 100, 5, 0);     // consumer stalls 10 cycles on byte 5
    fill_random(0);
    run_pass(0, 100, 0, 7);     // abort coincides with byte 7 handshake

    // Reset while DUT B sits in GAP_WAIT.
    fill_random(1);
    ready_v[1] = 1'b1;
    start_v[1] = 1'b1;
    tick();
    start_v[1] = 1'b0;
    for (int c = 0; c < 100 && !o_shift[1]; c++) tick();
    check("reached_shift", 1, o_shift[1], 1);
    tick();
    check("in_gap", 1, {o_busy[1], o_valid[1], o_shift[1]}, 3'b100);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ready_v[1] = 1'b0;
    check("rst_ctl", 1, {o_busy[1], o_load[1], o_shift[1], o_valid[1], o_done[1]}, 5'b00000);
    check("rst_cnt_data", 1, {o_cnt[1], o_data[1]}, 15'd0);
    tick();
    run_pass(1, 100, 0, 0);

    // Randomized passes with random consumer back-pressure and occasional aborts.
    for (int k = 0; k < 6; k++) begin
      int s;
      int ab;
      s  = k % 2;
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, DEPTH)) : 0;
      fill_random(s);
      run_pass(s, int'($urandom_range(30, 100)), 0, ab);
      tick();
    end

`ifdef SHIFT_CTRL_LOOP_EN
    fill_random(0);
    loop_test();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
